// File: rtl/gh_feeder_pkg.sv
// Shared widths, packer state encoding and the byte-reverse helper for the
// 512-bit stream feeder.
package gh_feeder_pkg;

  localparam int unsigned WORD_W        = 64;
  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned BLK_W         = 512;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [WORD_W-1:0] word_t;

  // Byte 0 <-> byte 7 reversal of one message word.
  function automatic word_t bswap64(input word_t w);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gh_stream512_feeder_if.sv
// Word stream in, hash-pipeline side band, and digest stream out of the feeder.
// The master modport is the feeder itself; slave is its environment.
interface gh_stream512_feeder_if;
  import gh_feeder_pkg::*;

  logic  s_valid;
  logic  s_ready;
  word_t s_data;
  logic  pipe_clken;
  blk_t  pipe_data;
  blk_t  pipe_hash;
  logic  m_valid;
  logic  m_ready;
  blk_t  m_hash;

  modport master (
    input  s_valid, s_data, pipe_hash, m_ready,
    output s_ready, pipe_clken, pipe_data, m_valid, m_hash
  );

  modport slave (
    output s_valid, s_data, pipe_hash, m_ready,
    input  s_ready, pipe_clken, pipe_data, m_valid, m_hash
  );

endinterface

// File: rtl/gh_tag_delay.sv
// Enable-gated PIPE_LAT-deep tag shift register that tracks which pipeline
// slot carries a real block; tag_o marks a valid digest on the pipeline output.
module gh_tag_delay #(
  parameter int unsigned PIPE_LAT = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tag_i,
  output logic tag_o
);

  logic [PIPE_LAT-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d = {tag_q[PIPE_LAT-2:0], tag_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q[PIPE_LAT-1];

endmodule

// File: rtl/gh_stream512_feeder.sv
// Packs 8 x 64-bit words into a 512-bit block, injects it into an external
// clock-enabled hash pipeline and captures the digest. Optional macro:
// GH_FEEDER_BSWAP_EN byte-reverses every input word before packing.
module gh_stream512_feeder
  import gh_feeder_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 120
) (
  input  logic                        clk,
  input  logic                        rst,
  gh_stream512_feeder_if.master       bus
);

  pack_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  blk_t             blk_q, blk_d;
  blk_t             m_hash_q, m_hash_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             clken_c;
  logic             accept_c;
  logic             tag_in_c;
  logic             tag_last;
  word_t            word_c;

  // Pipeline only advances when the held digest is free to be overwritten.
  assign clken_c  = !m_valid_q || bus.m_ready;
  assign accept_c = bus.s_valid && s_ready_q;

`ifdef GH_FEEDER_BSWAP_EN
  assign word_c = bswap64(bus.s_data);
`else
  assign word_c = bus.s_data;
`endif

  // Packer: shift words in so word 0 ends up in the top lane.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    tag_in_c = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          blk_d = {blk_q[BLK_W-WORD_W-1:0], word_c};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS_PER_BLK - 1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (clken_c) begin
          state_d  = ST_FILL;
          tag_in_c = 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase
    s_ready_d = (state_d == ST_FILL);
  end

  // Digest capture, frozen together with the pipeline.
  always_comb begin
    m_valid_d = m_valid_q;
    m_hash_d  = m_hash_q;
    if (clken_c) begin
      m_valid_d = tag_last;
      if (tag_last) begin
        m_hash_d = bus.pipe_hash;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      blk_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_hash_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_hash_q  <= m_hash_d;
    end
  end

  gh_tag_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .en_i  (clken_c),
    .tag_i (tag_in_c),
    .tag_o (tag_last)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.pipe_clken = clken_c;
  assign bus.pipe_data  = blk_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_hash     = m_hash_q;

endmodule

// File: tb/tb_gh_stream512_feeder.sv
// Directed bench for gh_stream512_feeder; the hash pipeline is a clken-gated
// PIPE_LAT-stage delay line, so every digest must equal its packed block.
module tb_gh_stream512_feeder;
  import gh_feeder_pkg::*;

  localparam int unsigned L = 120;

`ifdef GH_FEEDER_BSWAP_EN
  localparam logic [63:0] W0_EXP = 64'h0807060504030201;
`else
  localparam logic [63:0] W0_EXP = 64'h0102030405060708;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mv_seen = 0;
  int   wcnt  = 0;
  int   acc;
  int   rel;
  int   guard;

  logic [63:0]  cur [8];
  logic [511:0] exp_q [$];
  logic [511:0] got_q [$];
  int           got_t [$];
  logic [511:0] stub  [L];

  gh_stream512_feeder_if bus ();

  gh_stream512_feeder #(.PIPE_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in hash pipeline: pure delay, advancing only on pipe_clken.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(L); i++) stub[i] <= '0;
    end else if (bus.pipe_clken) begin
      for (int i = int'(L) - 1; i > 0; i--) stub[i] <= stub[i-1];
      stub[0] <= bus.pipe_data;
    end
  end
  assign bus.pipe_hash = stub[L-1];

  // Record consumed digests with the index of the consuming edge.
  always @(posedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_hash);
      got_t.push_back(cyc);
    end
    if (!rst && bus.m_valid) mv_seen <= mv_seen + 1;
    cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mdl_word(input logic [63:0] w);
`ifdef GH_FEEDER_BSWAP_EN
    return {<<8{w}};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word; returns #1 after its accept edge with s_valid dropped.
  task automatic push(input logic [63:0] w);
    logic [511:0] b;
    int g;
    g = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    while (!bus.s_ready && g < 50) begin
      step(1);
      g++;
    end
    if (g == 50) check("push_timeout", 512'(bus.s_ready), 512'(1));
    step(1);
    bus.s_valid = 1'b0;
    cur[wcnt] = mdl_word(w);
    if (wcnt == 7) begin
      b = '0;
      for (int i = 0; i < 8; i++) b[511-64*i -: 64] = cur[i];
      exp_q.push_back(b);
      wcnt = 0;
    end else begin
      wcnt++;
    end
  endtask

  task automatic check_digests(input string tag);
    check({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_hash"}, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_s_ready",   512'(bus.s_ready),    512'(1));
    check("rst_clken",     512'(bus.pipe_clken), 512'(1));
    check("rst_m_valid",   512'(bus.m_valid),    512'(0));
    check("rst_m_hash",    bus.m_hash,           512'(0));
    check("rst_pipe_data", bus.pipe_data,        512'(0));

    // Single block 0..7: capture on the (L+1)th edge after word 7, one pulse
    clear_queues();
    for (int i = 0; i < 8; i++) push(64'(i));
    acc = cyc - 1;
    check("t1_hold_s_ready", 512'(bus.s_ready), 512'(0));
    check("t1_pipe_data",    bus.pipe_data,     exp_q[0]);
    step(1);
    check("t1_fill_s_ready", 512'(bus.s_ready), 512'(1));
    step(int'(L) - 1);
    check("t1_mv_early", 512'(bus.m_valid), 512'(0));
    step(1);
    check("t1_mv_rise",  512'(bus.m_valid), 512'(1));
    check("t1_m_hash",   bus.m_hash,        exp_q[0]);
    step(1);
    check("t1_mv_fall",  512'(bus.m_valid), 512'(0));
    check("t1_latency",  512'(got_t[0] - acc), 512'(L + 2));
    check_digests("t1");

    // Three back-to-back blocks, 9-cycle spacing
    clear_queues();
    for (int i = 0; i < 24; i++) push(64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1));
    step(int'(L) + 30);
    check_digests("t2");
    check("t2_gap01", 512'(got_t[1] - got_t[0]), 512'(9));
    check("t2_gap12", 512'(got_t[2] - got_t[1]), 512'(9));

    // Backpressure with two blocks in flight
    clear_queues();
    for (int i = 0; i < 16; i++) push({32'hC0DE_0000 + 32'(i), 32'hFFFF_0000 - 32'(i)});
    guard = 0;
    while (!bus.m_valid && guard < 400) begin
      step(1);
      guard++;
    end
    check("t3_mv_seen", 512'(bus.m_valid), 512'(1));
    bus.m_ready = 1'b0;
    step(50);
    check("t3_clken_low", 512'(bus.pipe_clken), 512'(0));
    check("t3_mv_hold",   512'(bus.m_valid),    512'(1));
    check("t3_hash_hold", bus.m_hash,           exp_q[0]);
    check("t3_none_yet",  512'(got_q.size()),   512'(0));
    bus.m_ready = 1'b1;
    rel = cyc;
    step(30);
    check_digests("t3");
    check("t3_rel_first",  512'(got_t[0]), 512'(rel));
    check("t3_rel_second", 512'(got_t[1]), 512'(rel + 9));

    // Reset with one block in flight and a partial block in the packer
    clear_queues();
    for (int i = 0; i < 13; i++) push(64'hDEAD_BEEF_0000_0000 | 64'(i));
    rst = 1'b1;
    wcnt = 0;
    exp_q.delete();
    step(2);
    rst = 1'b0;
    rel = mv_seen;
    check("t4_s_ready",   512'(bus.s_ready), 512'(1));
    check("t4_pipe_data", bus.pipe_data,     512'(0));
    step(int'(L) + 20);
    check("t4_no_mvalid", 512'(mv_seen), 512'(rel));
    for (int i = 0; i < 8; i++) push(64'h1111_2222_3333_0000 | 64'(i));
    acc = cyc - 1;
    step(int'(L) + 10);
    check_digests("t4");
    check("t4_latency", 512'(got_t[0] - acc), 512'(L + 2));

    // Byte-order of the top word
    clear_queues();
    push(64'h0102030405060708);
    for (int i = 1; i < 8; i++) push(64'(i));
    check("t5_word0", 512'(bus.pipe_data[511:448]), 512'(W0_EXP));
    step(int'(L) + 10);
    check_digests("t5");

    // Random input gaps; s_ready must stay low right after each block completes
    clear_queues();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) step(int'($urandom_range(1, 3)));
        push({$urandom, $urandom});
      end
      check("t6_hold_s_ready", 512'(bus.s_ready), 512'(0));
    end
    step(int'(L) + 40);
    check_digests("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
